// File: rtl/uart_pkg.sv
// Shared types and constants for the UART endpoint: FSM state encodings,
// frame size and the request-type (rors) encodings.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W      = $clog2(UART_DATA_BITS);

  localparam logic RORS_SEND = 1'b1;
  localparam logic RORS_RECV = 1'b0;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_io_unit_if.sv
// Request/response handshake between the control FSM (master) and the
// UART endpoint (slave).
interface uart_io_unit_if;
  import uart_pkg::*;

  logic                      uart_go;
  logic                      rors;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      uart_done;

  modport master (
    output uart_go, rors, tx_data,
    input  rx_data, uart_done
  );

  modport slave (
    input  uart_go, rors, tx_data,
    output rx_data, uart_done
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer. With UART_RXBUF_EN defined it is a DEPTH-entry
// circular FIFO (pointers carry one extra wrap bit); otherwise it is a
// single holding register with a valid bit.
// A push while full only lands if a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      push_i,
  input  logic [UART_DATA_BITS-1:0] wdata_i,
  input  logic                      pop_i,
  output logic [UART_DATA_BITS-1:0] rdata_o,
  output logic                      full_o,
  output logic                      empty_o
);

  // Depth only sizes the circular buffer; it must be a power of two >= 2.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_not_pow2
  end

  logic do_push;
  logic do_pop;

`ifdef UART_RXBUF_EN
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]             wr_ptr_q;
  logic [PW-1:0]             rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; the wrap bit rolls over naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage array, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
`else
  logic                      valid_q;
  logic [UART_DATA_BITS-1:0] data_q;

  assign empty_o = ~valid_q;
  assign full_o  = valid_q;
  assign do_pop  = pop_i & valid_q;
  assign do_push = push_i & (~valid_q | do_pop);
  assign rdata_o = data_q;

  // Single holding register: a refill in the pop cycle keeps it valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (do_push) begin
        valid_q <= 1'b1;
        data_q  <= wdata_i;
      end else if (do_pop) begin
        valid_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_io_unit.sv
// UART endpoint: 8N1 transmitter and receiver serving sendb/recvb requests
// from the control FSM. Build option UART_RXBUF_EN selects a RXBUF_DEPTH
// receive FIFO instead of a single holding register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// TX_IDLE  | txd high, waiting for a send request
// TX_START | driving the start bit (0) for CLK_PER_BIT cycles
// TX_DATA  | driving data bit tx_bit_q, LSB first
// TX_STOP  | driving the stop bit (1); completion pulses on exit
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | waiting half a bit, then rejecting glitches
// RX_DATA  | sampling data bit rx_bit_q at mid-bit
// RX_STOP  | sampling the stop bit; push on 1, frame error on 0
module uart_io_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned RXBUF_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rstn,
  uart_io_unit_if.slave bus,
  output logic          txd,
  input  logic          rxd,
  output logic          rx_overrun,
  output logic          rx_frame_err
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(UART_DATA_BITS - 1);

  tx_state_t                 tx_state_q, tx_state_d;
  logic [CNT_W-1:0]          tx_cnt_q, tx_cnt_d;
  logic [BIT_IDX_W-1:0]      tx_bit_q, tx_bit_d;
  logic [UART_DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                      txd_q, txd_d;
  logic                      tx_req, tx_done;

  rx_state_t                 rx_state_q, rx_state_d;
  logic [CNT_W-1:0]          rx_cnt_q, rx_cnt_d;
  logic [BIT_IDX_W-1:0]      rx_bit_q, rx_bit_d;
  logic [UART_DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                      rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic                      rxd_s, rx_fall;
  logic                      rx_push, rx_ferr_set;

  logic                      rx_pending_q, rx_pending_d;
  logic                      rx_req, rx_want, rx_bypass, rx_deliver;
  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                      done_q;
  logic                      overrun_q, ferr_q;
  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rdata;

  assign tx_req  = bus.uart_go & (bus.rors == RORS_SEND) & (tx_state_q == TX_IDLE);
  assign rx_req  = bus.uart_go & (bus.rors == RORS_RECV) & ~rx_pending_q;
  assign rxd_s   = rxd_s2_q;
  assign rx_fall = rxd_s3_q & ~rxd_s2_q;

  // TX next-state: bit timer reloads on every state change.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_done    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (tx_req) begin
          tx_state_d = TX_START;
          tx_cnt_d   = BIT_LAST;
          tx_shift_d = bus.tx_data;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LAST;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + BIT_IDX_W'(1);
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_IDLE;
          tx_done    = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX next-state: start is re-checked at half a bit, then mid-bit sampling.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rxd_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rxd_s, rx_shift_q[UART_DATA_BITS-1:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + BIT_IDX_W'(1);
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d  = RX_IDLE;
          rx_push     = rxd_s;
          rx_ferr_set = ~rxd_s;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receive handshake: a byte arriving into an empty buffer while a request
  // waits goes straight to rx_data so completion lands one cycle after the
  // stop sample instead of two.
  always_comb begin
    rx_want      = rx_pending_q | rx_req;
    rx_bypass    = rx_want & fifo_empty & rx_push;
    fifo_pop     = rx_want & ~fifo_empty;
    fifo_push    = rx_push & ~rx_bypass;
    rx_deliver   = fifo_pop | rx_bypass;
    rx_pending_d = rx_want & ~rx_deliver;
    rx_data_d    = rx_data_q;
    if (fifo_pop)       rx_data_d = fifo_rdata;
    else if (rx_bypass) rx_data_d = rx_shift_q;
  end

  // All state registers; reset aborts both frames and parks txd high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      txd_q        <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rxd_s1_q     <= 1'b1;
      rxd_s2_q     <= 1'b1;
      rxd_s3_q     <= 1'b1;
      rx_pending_q <= 1'b0;
      rx_data_q    <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      txd_q        <= txd_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rxd_s1_q     <= rxd;
      rxd_s2_q     <= rxd_s1_q;
      rxd_s3_q     <= rxd_s2_q;
      rx_pending_q <= rx_pending_d;
      rx_data_q    <= rx_data_d;
      done_q       <= tx_done | rx_deliver;
      overrun_q    <= overrun_q | (fifo_push & fifo_full & ~fifo_pop);
      ferr_q       <= ferr_q | rx_ferr_set;
    end
  end

  uart_rx_fifo #(
    .DEPTH (RXBUF_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (fifo_push),
    .wdata_i (rx_shift_q),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign txd           = txd_q;
  assign rx_overrun    = overrun_q;
  assign rx_frame_err  = ferr_q;
  assign bus.uart_done = done_q;
  assign bus.rx_data   = rx_data_q;

endmodule

// File: tb/tb_uart_io_unit.sv
// Bench for uart_io_unit at CLK_PER_BIT=4. Received bytes are tracked with
// a scoreboard queue: pushed when a good frame is driven, popped when a
// receive completes.
module tb_uart_io_unit;

  localparam int CPB = 4;

  logic clk;
  logic rstn;
  logic txd;
  logic rxd;
  logic rx_overrun;
  logic rx_frame_err;

  uart_io_unit_if bus_if ();

  uart_io_unit #(
    .CLK_PER_BIT (CPB),
    .RXBUF_DEPTH (16)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus_if),
    .txd          (txd),
    .rxd          (rxd),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  bit rx_expect = 1'b0;
  logic [7:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: counts pulses and scores receive results.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.uart_done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (rx_expect) begin
          rx_expect = 1'b0;
          if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
          else chk("rx_data", bus_if.rx_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (CPB) tick();
    end
    rxd = 1'b1;
  endtask

  task automatic do_recv(output int req_cyc);
    rx_expect = 1'b1;
    bus_if.rors = 1'b0;
    bus_if.uart_go = 1'b1;
    req_cyc = cyc;
    tick();
    bus_if.uart_go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget, input int exp_cyc);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == d0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else chk({tag, "_cycle"}, last_done_cyc, exp_cyc);
  endtask

  task automatic run_send(input logic [7:0] b);
    logic [9:0] fr;
    int d0;
    fr = {1'b1, b, 1'b0};
    d0 = done_cnt;
    bus_if.rors = 1'b1;
    bus_if.tx_data = b;
    bus_if.uart_go = 1'b1;
    chk("tx_c0_idle", txd, 1'b1);
    tick();
    bus_if.uart_go = 1'b0;
    bus_if.tx_data = ~b;
    for (int n = 1; n <= 10 * CPB; n++) begin
      chk("tx_bit", txd, fr[(n - 1) / CPB]);
      if (n < 10 * CPB) tick();
    end
    tick();
    chk("tx_no_early_done", done_cnt - d0, 32'd0);
    chk("tx_done", bus_if.uart_done, 1'b1);
    chk("tx_stop_idle", txd, 1'b1);
    tick();
    chk("tx_done_once", bus_if.uart_done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, k, d0;
    rstn = 1'b0;
    rxd = 1'b1;
    bus_if.uart_go = 1'b0;
    bus_if.rors = 1'b0;
    bus_if.tx_data = 8'h00;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    chk("rst_txd", txd, 1'b1);
    chk("rst_done", bus_if.uart_done, 1'b0);
    chk("rst_rx_data", bus_if.rx_data, 8'h00);
    chk("rst_overrun", rx_overrun, 1'b0);
    chk("rst_frame_err", rx_frame_err, 1'b0);

    // Send 0xA5 and check the full waveform.
    run_send(8'hA5);
    repeat (3) tick();

    // Frame first, then a request served from the buffer.
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, k);
    repeat (4) tick();
    d0 = done_cnt;
    do_recv(s);
    wait_done("rx_buffered", d0, 10, s + 1);

    // Request first, completion one cycle after the stop sample.
    d0 = done_cnt;
    do_recv(s);
    repeat (3) tick();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, k);
    wait_done("rx_pending", d0, 20, k + 41);
    repeat (3) tick();

    // One-cycle glitch must not produce a byte.
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (20) tick();
    d0 = done_cnt;
    do_recv(s);
    repeat (50) tick();
    chk("glitch_no_done", done_cnt - d0, 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, k);
    wait_done("glitch_recover", d0, 20, k + 41);
    repeat (3) tick();

    // Low stop bit: frame error, byte dropped.
    chk("ferr_before", rx_frame_err, 1'b0);
    send_frame(8'h77, 1'b0, k);
    repeat (4) tick();
    chk("ferr_set", rx_frame_err, 1'b1);
    d0 = done_cnt;
    do_recv(s);
    repeat (50) tick();
    chk("ferr_no_byte", done_cnt - d0, 32'd0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, k);
    wait_done("ferr_recover", d0, 20, k + 41);
    chk("ferr_sticky", rx_frame_err, 1'b1);
    repeat (3) tick();

    // Buffer overflow.
`ifdef UART_RXBUF_EN
    for (int b = 1; b <= 16; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, k);
      repeat (2) tick();
    end
    repeat (4) tick();
    chk("ovr_at_full", rx_overrun, 1'b0);
    send_frame(8'd17, 1'b1, k);
    repeat (4) tick();
    chk("ovr_set", rx_overrun, 1'b1);
    for (int r = 0; r < 16; r++) begin
      d0 = done_cnt;
      do_recv(s);
      wait_done("ovr_pop", d0, 10, s + 1);
      tick();
    end
`else
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, k);
    repeat (4) tick();
    chk("ovr_at_full", rx_overrun, 1'b0);
    send_frame(8'h22, 1'b1, k);
    repeat (4) tick();
    chk("ovr_set", rx_overrun, 1'b1);
    d0 = done_cnt;
    do_recv(s);
    wait_done("ovr_pop", d0, 10, s + 1);
`endif
    chk("sb_drained", exp_q.size(), 32'd0);
    repeat (3) tick();

    // Reset mid-TX: txd rises asynchronously and no completion follows.
    d0 = done_cnt;
    bus_if.rors = 1'b1;
    bus_if.tx_data = 8'h00;
    bus_if.uart_go = 1'b1;
    tick();
    bus_if.uart_go = 1'b0;
    repeat (9) tick();
    chk("rst_mid_low", txd, 1'b0);
    #2;
    rstn = 1'b0;
    rx_expect = 1'b0;
    #1;
    chk("rst_async_txd", txd, 1'b1);
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    chk("rst2_overrun", rx_overrun, 1'b0);
    chk("rst2_frame_err", rx_frame_err, 1'b0);
    chk("rst2_rx_data", bus_if.rx_data, 8'h00);
    repeat (60) tick();
    chk("rst_no_done", done_cnt - d0, 32'd0);

    run_send(8'hC3);
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_io_unit.md
# uart_io_unit

UART endpoint on the far side of the control FSM's `uart_go`/`rors`/`uart_done` handshake: executes `sendb` (transmit one byte) and `recvb` (return one received byte) requests. It serializes and deserializes 8N1 frames on the board `txd`/`rxd` pins and holds received bytes until a `recvb` asks for them. It sits in the core beside the datapath; `tx_data` comes from the register file and `rx_data` feeds the register writeback mux.

## Interface
- `CLK_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `RXBUF_DEPTH`, 16: receive FIFO depth (power of two); used only with `UART_RXBUF_EN`.
- `clk`  in  1: core clock; single clock domain.
- `rstn`  in  1: reset, asynchronous, active-low.
- `uart_go`  in  1: one-cycle request pulse from the control FSM.
- `rors`  in  1: request type, sampled with `uart_go`: 1 = send, 0 = receive.
- `tx_data`  in  8: byte to send, sampled on `uart_go & rors`.
- `rx_data`  out  8: received byte; valid with `uart_done` of a receive; held until the next receive completes.
- `uart_done`  out  1: one-cycle completion pulse.
- `txd`  out  1: serial out, idle high.
- `rxd`  in  1: serial in, asynchronous to `clk`.
- `rx_overrun`  out  1: sticky; a received byte was dropped because the buffer was full.
- `rx_frame_err`  out  1: sticky; a stop bit was sampled low.

## Operation
- Reset values: `txd`=1, `uart_done`=0, `rx_data`=0, `rx_overrun`=0, `rx_frame_err`=0. The buffer is empty and both FSMs are IDLE.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1, with no parity.
- TX FSM: IDLE → START → DATA (bit index 0..7) → STOP → IDLE.
  - `uart_go & rors` in IDLE latches `tx_data` into a shift register.
  - Each state lasts `CLK_PER_BIT` cycles, counted by a bit-timer counter that reloads on every state change.
- RX FSM: IDLE → START → DATA → STOP → IDLE.
  - `rxd` passes through a 2-flop synchronizer.
  - A falling edge in IDLE enters START, which re-samples at `CLK_PER_BIT/2`. If the line is high there, the start was a glitch and the FSM returns to IDLE.
  - Data bits are sampled at mid-bit, every `CLK_PER_BIT` cycles.
  - STOP samples mid-bit. If the sample is 1, the byte is pushed into the buffer. If it is 0, the byte is discarded and `rx_frame_err` is set.
  - The FSM then returns to IDLE and accepts a new start edge immediately.
  - The RX FSM runs continuously, independent of requests.
- Receive request (`uart_go & ~rors`):
  - Sets `rx_pending`.
  - While `rx_pending` is set and the buffer is non-empty: pop one byte to `rx_data`, pulse `uart_done`, and clear `rx_pending`.
- Push and pop in the same cycle are both performed. A push into a full buffer is dropped and sets `rx_overrun`, unless a pop occurs in the same cycle, in which case the push succeeds.
- `uart_go` while the selected side is busy (TX not IDLE, or `rx_pending` set) is ignored. The control FSM never issues such a request.
- Sticky flags clear only on reset.
- Asserting reset mid-frame aborts both FSMs: `txd` returns high asynchronously and any partial RX byte is lost.

## Timing
- Send: `uart_go` arrives in cycle 0.
  - `txd` is low during cycles 1..`CLK_PER_BIT`.
  - Data bit i occupies cycles (i+1)·`CLK_PER_BIT`+1 .. (i+2)·`CLK_PER_BIT`.
  - The stop bit ends at cycle 10·`CLK_PER_BIT`.
  - `uart_done` pulses in cycle 10·`CLK_PER_BIT`+1, with `txd`=1.
- Receive with buffered data: `uart_done` and the valid `rx_data` appear in cycle 1.
- Receive with empty buffer: `uart_done` pulses the cycle after the push, i.e. the cycle after the STOP mid-sample.
- Input latency: 2 cycles of synchronizer latency on `rxd`.
- Outputs: `txd` and `uart_done` are registered outputs.

## Configuration
- `UART_RXBUF_EN` defined: the receive buffer is a `RXBUF_DEPTH`-entry circular FIFO.
  - Read and write pointers are log2(`RXBUF_DEPTH`)+1 bits; the extra MSB distinguishes full from empty, and the pointers wrap naturally.
- Not defined: the receive buffer is a single holding register with a valid bit (depth 1). A byte arriving while it is valid is dropped and sets `rx_overrun`.

## Structure
- Shared package `uart_pkg`: `tx_state_t` and `rx_state_t` enums, frame constants (`UART_DATA_BITS`=8), and the `rors` encodings `RORS_SEND`=1'b1 and `RORS_RECV`=1'b0.
- One sub-module, `uart_rx_fifo`: the buffer, with push/pop/full/empty ports.
  - Its internals are selected by `UART_RXBUF_EN`.
  - The TX FSM, RX FSM and handshake logic stay in the top module.

## Test plan
All scenarios run with `CLK_PER_BIT`=4.
- Send 0xA5: `uart_go`=1, `rors`=1 at cycle 0 → `txd` waveform 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles starting in cycle 1; `uart_done` in cycle 41 only.
- Drive a 0x3C frame on `rxd`, then receive request → `uart_done` in the next cycle with `rx_data`=0x3C. Issue the request first instead → `uart_done` one cycle after the stop-bit sample.
- Glitch: `rxd` low for 1 cycle → no byte is buffered and a later receive request stays pending.
- Stop bit driven 0 → `rx_frame_err`=1 and no byte is buffered.
- Overflow, with `UART_RXBUF_EN`: push 17 frames with no request → 16 requests return bytes 1..16 in order and `rx_overrun`=1. Without the macro, send 2 frames → the request returns byte 1 and `rx_overrun`=1.
- Assert `rstn` low mid-TX-frame → `txd`=1 asynchronously and no `uart_done`. After release, a new send completes normally.
